// File: rtl/clock_timekeeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clock_timekeeper
// Description : Time-of-day core for the 7-segment clock. Prescaler, HH:MM:SS
//               counters, hour/minute set buttons, 12/24 h display mapping and
//               a TIME/SECS display page FSM with auto-revert. Drives four BCD
//               digits plus blank, colon and PM flags.
//               Optional alarm: define CLOCK_TIMEKEEPER_ALARM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_timekeeper #(
    parameter int CLK_HZ         = 10_000_000,
    parameter int REVERT_SECONDS = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_hr_i,
    input  logic        inc_min_i,
    input  logic        page_sw_i,
    input  logic        mode_12h_i,
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    input  logic        alarm_en_i,
    input  logic [4:0]  alarm_hr_i,
    input  logic [5:0]  alarm_min_i,
    input  logic        alarm_ack_i,
    output logic        alarm_o,
`endif
    output logic        tick_o,
    output logic        half_hz_o,
    output logic [15:0] disp_o,
    output logic [3:0]  blank_o,
    output logic        colon_o,
    output logic        pm_o
);

    localparam int                   PRESC_W     = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0]   PRESC_LAST  = PRESC_W'(CLK_HZ - 1);
    localparam logic [3:0]           REVERT_LOAD = 4'(REVERT_SECONDS);

    typedef enum logic [0:0] {
        PAGE_TIME = 1'b0,
        PAGE_SECS = 1'b1
    } page_t;

    // Binary 0..59 to two BCD digits {tens, ones}
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        ones = v[3:0];
        if (v >= 6'd50) begin
            tens = 4'd5; ones = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            tens = 4'd4; ones = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            tens = 4'd3; ones = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            tens = 4'd2; ones = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            tens = 4'd1; ones = 4'(v - 6'd10);
        end
        return {tens, ones};
    endfunction

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [4:0]         hr_q, hr_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    page_t              page_q, page_d;
    logic [3:0]         revert_q, revert_d;
    logic               hr_btn_q, min_btn_q, page_btn_q;
    logic               tick_q, tick_d;
    logic               half_hz_q, half_hz_d;
    logic [15:0]        disp_q, disp_d;
    logic [3:0]         blank_q, blank_d;
    logic               colon_q, colon_d;
    logic               pm_q, pm_d;

    logic               hr_edge, min_edge, page_edge, set_edge, tick_w;
    logic [4:0]         hr_disp;
    logic [7:0]         hr_bcd, min_bcd, sec_bcd;

    // Previous-level registers are reset to 1 so a button held through reset fires nothing
    assign hr_edge   = inc_hr_i  & ~hr_btn_q;
    assign min_edge  = inc_min_i & ~min_btn_q;
    assign page_edge = page_sw_i & ~page_btn_q;
    assign set_edge  = hr_edge | min_edge;

    // Prescaler and time counters; a set edge restarts the second and swallows the tick
    always_comb begin
        presc_d = presc_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_w  = 1'b0;
        if (set_edge) begin
            presc_d = '0;
            sec_d   = 6'd0;
            if (min_edge) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (hr_edge)  hr_d  = (hr_q  == 5'd23) ? 5'd0 : hr_q  + 5'd1;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_w  = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Page FSM: page edge (re)arms the seconds page, ticks count it back down to TIME
    always_comb begin
        page_d   = page_q;
        revert_d = revert_q;
        case (page_q)
            PAGE_TIME: begin
                if (page_edge) begin
                    page_d   = PAGE_SECS;
                    revert_d = REVERT_LOAD;
                end
            end
            PAGE_SECS: begin
                if (page_edge) begin
                    revert_d = REVERT_LOAD;
                end else if (tick_w) begin
                    revert_d = revert_q - 4'd1;
                    if (revert_q == 4'd1) page_d = PAGE_TIME;
                end
            end
            default: begin
                page_d   = PAGE_TIME;
                revert_d = 4'd0;
            end
        endcase
    end

    // Display formatting from current state; registered so outputs lag state by one cycle
    always_comb begin
        if (mode_12h_i) begin
            if (hr_q == 5'd0)       hr_disp = 5'd12;
            else if (hr_q > 5'd12)  hr_disp = hr_q - 5'd12;
            else                    hr_disp = hr_q;
        end else begin
            hr_disp = hr_q;
        end
        hr_bcd    = to_bcd({1'b0, hr_disp});
        min_bcd   = to_bcd(min_q);
        sec_bcd   = to_bcd(sec_q);
        tick_d    = tick_w;
        half_hz_d = sec_q[0];
        pm_d      = (hr_q >= 5'd12);
        disp_d    = {hr_bcd, min_bcd};
        blank_d   = 4'b0000;
        colon_d   = ~sec_q[0];
        if (mode_12h_i && (hr_bcd[7:4] == 4'd0)) blank_d = 4'b1000;
        if (page_q == PAGE_SECS) begin
            disp_d  = {8'h00, sec_bcd};
            blank_d = 4'b1100;
            colon_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            hr_q       <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            page_q     <= PAGE_TIME;
            revert_q   <= 4'd0;
            hr_btn_q   <= 1'b1;
            min_btn_q  <= 1'b1;
            page_btn_q <= 1'b1;
            tick_q     <= 1'b0;
            half_hz_q  <= 1'b0;
            disp_q     <= 16'h0000;
            blank_q    <= 4'b0000;
            colon_q    <= 1'b1;
            pm_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            page_q     <= page_d;
            revert_q   <= revert_d;
            hr_btn_q   <= inc_hr_i;
            min_btn_q  <= inc_min_i;
            page_btn_q <= page_sw_i;
            tick_q     <= tick_d;
            half_hz_q  <= half_hz_d;
            disp_q     <= disp_d;
            blank_q    <= blank_d;
            colon_q    <= colon_d;
            pm_q       <= pm_d;
        end
    end

    assign tick_o    = tick_q;
    assign half_hz_o = half_hz_q;
    assign disp_o    = disp_q;
    assign blank_o   = blank_q;
    assign colon_o   = colon_q;
    assign pm_o      = pm_q;

`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    logic alarm_q, alarm_d;
    logic ack_btn_q;
    logic ack_edge;

    assign ack_edge = alarm_ack_i & ~ack_btn_q;

    // Alarm latches only on a real tick reaching HH:MM:00; clearing beats setting
    always_comb begin
        alarm_d = alarm_q;
        if (tick_w && alarm_en_i && (hr_d == alarm_hr_i) && (min_d == alarm_min_i) && (sec_d == 6'd0))
            alarm_d = 1'b1;
        if (ack_edge || !alarm_en_i)
            alarm_d = 1'b0;
    end

    // Alarm state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alarm_q   <= 1'b0;
            ack_btn_q <= 1'b1;
        end else begin
            alarm_q   <= alarm_d;
            ack_btn_q <= alarm_ack_i;
        end
    end

    assign alarm_o = alarm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_timekeeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_clock_timekeeper
// Description : Self-checking bench for clock_timekeeper (CLK_HZ=4,
//               REVERT_SECONDS=3). Expected display frames are pushed to a
//               scoreboard queue when stimulus is applied and popped when the
//               DUT shows the result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_timekeeper;

    localparam int CLK_HZ = 4;
    localparam int REV    = 3;

    logic        clk         = 1'b0;
    logic        rst_i       = 1'b1;
    logic        inc_hr_i    = 1'b0;
    logic        inc_min_i   = 1'b0;
    logic        page_sw_i   = 1'b0;
    logic        mode_12h_i  = 1'b0;
    logic        tick_o;
    logic        half_hz_o;
    logic [15:0] disp_o;
    logic [3:0]  blank_o;
    logic        colon_o;
    logic        pm_o;
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    logic        alarm_en_i  = 1'b0;
    logic [4:0]  alarm_hr_i  = 5'd0;
    logic [5:0]  alarm_min_i = 6'd0;
    logic        alarm_ack_i = 1'b0;
    logic        alarm_o;
`endif

    clock_timekeeper #(.CLK_HZ(CLK_HZ), .REVERT_SECONDS(REV)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .inc_hr_i   (inc_hr_i),
        .inc_min_i  (inc_min_i),
        .page_sw_i  (page_sw_i),
        .mode_12h_i (mode_12h_i),
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
        .alarm_en_i (alarm_en_i),
        .alarm_hr_i (alarm_hr_i),
        .alarm_min_i(alarm_min_i),
        .alarm_ack_i(alarm_ack_i),
        .alarm_o    (alarm_o),
`endif
        .tick_o     (tick_o),
        .half_hz_o  (half_hz_o),
        .disp_o     (disp_o),
        .blank_o    (blank_o),
        .colon_o    (colon_o),
        .pm_o       (pm_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] disp;
        logic [3:0]  blank;
        logic        colon;
        logic        pm;
        logic        half;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference time/page model
    int mh = 0, mm = 0, ms = 0, rev = 0;
    bit secs_page = 0;

    function automatic frame_t mk_frame();
        frame_t f;
        int dh;
        dh = mh;
        if (mode_12h_i) begin
            dh = mh % 12;
            if (dh == 0) dh = 12;
        end
        f.pm   = (mh >= 12);
        f.half = (ms % 2 == 1);
        if (secs_page) begin
            f.disp  = {8'h00, 4'(ms / 10), 4'(ms % 10)};
            f.blank = 4'b1100;
            f.colon = 1'b1;
        end else begin
            f.disp  = {4'(dh / 10), 4'(dh % 10), 4'(mm / 10), 4'(mm % 10)};
            f.blank = (mode_12h_i && dh < 10) ? 4'b1000 : 4'b0000;
            f.colon = (ms % 2 == 0);
        end
        return f;
    endfunction

    task automatic model_tick();
        ms++;
        if (ms == 60) begin
            ms = 0; mm++;
            if (mm == 60) begin
                mm = 0; mh = (mh + 1) % 24;
            end
        end
        if (secs_page) begin
            rev--;
            if (rev == 0) secs_page = 0;
        end
    endtask

    // Scoreboard consumer: compare the oldest expected frame with the DUT outputs
    task automatic sb_pop(input string tag);
        frame_t e, a;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty when output frame appeared", tag);
        end else begin
            e = exp_q.pop_front();
            a = {disp_o, blank_o, colon_o, pm_o, half_hz_o};
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got disp=%h blank=%b colon=%b pm=%b half=%b, required disp=%h blank=%b colon=%b pm=%b half=%b",
                         tag, a.disp, a.blank, a.colon, a.pm, a.half, e.disp, e.blank, e.colon, e.pm, e.half);
            end
        end
    endtask

    // One-cycle button pulse; caller is at a falling clock edge
    task automatic press(input bit hr, input bit mn, input bit pg);
        inc_hr_i  = hr;
        inc_min_i = mn;
        page_sw_i = pg;
        @(negedge clk);
        inc_hr_i  = 1'b0;
        inc_min_i = 1'b0;
        page_sw_i = 1'b0;
        @(negedge clk);
        if (hr || mn) begin
            ms = 0;
            if (mn) mm = (mm + 1) % 60;
            if (hr) mh = (mh + 1) % 24;
        end
        if (pg) begin
            secs_page = 1;
            rev = REV;
        end
    endtask

    task automatic expect_ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            int waited;
            model_tick();
            exp_q.push_back(mk_frame());
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (tick_o !== 1'b1 && waited < CLK_HZ + 1);
            n_checks++;
            if (tick_o !== 1'b1) begin
                n_fail++;
                $display("FAIL %s tick: tick_o=%b after %0d cycles, required 1", tag, tick_o, waited);
            end
            @(negedge clk);
            n_checks++;
            if (tick_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s tick width: tick_o=%b, required 0", tag, tick_o);
            end
            sb_pop(tag);
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        inc_hr_i = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 6;
        if (tick_o !== 1'b0)      begin n_fail++; $display("FAIL rst_tick: got %b required 0", tick_o); end
        if (half_hz_o !== 1'b0)   begin n_fail++; $display("FAIL rst_half: got %b required 0", half_hz_o); end
        if (disp_o !== 16'h0000)  begin n_fail++; $display("FAIL rst_disp: got %h required 0000", disp_o); end
        if (blank_o !== 4'b0000)  begin n_fail++; $display("FAIL rst_blank: got %b required 0000", blank_o); end
        if (colon_o !== 1'b1)     begin n_fail++; $display("FAIL rst_colon: got %b required 1", colon_o); end
        if (pm_o !== 1'b0)        begin n_fail++; $display("FAIL rst_pm: got %b required 0", pm_o); end
        rst_i = 1'b0;
        model_tick();
        exp_q.push_back(mk_frame());
        for (int i = 0; i < CLK_HZ; i++) begin
            logic want;
            @(negedge clk);
            want = (i == CLK_HZ - 1);
            n_checks++;
            if (tick_o !== want) begin
                n_fail++;
                $display("FAIL first_tick cycle %0d: tick_o=%b required %b", i + 1, tick_o, want);
            end
        end
        inc_hr_i = 1'b0;
        @(negedge clk);
        sb_pop("first_second");
    endtask

    task automatic test_rollover();
        for (int i = 0; i < 23; i++) press(1, 0, 0);
        exp_q.push_back(mk_frame());
        sb_pop("preload_hr");
        for (int i = 0; i < 59; i++) press(0, 1, 0);
        exp_q.push_back(mk_frame());
        sb_pop("preload_min");
        expect_ticks(59, "preload_sec");
        expect_ticks(1, "day_rollover");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (tick_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rollover_spurious: tick_o=%b required 0", tick_o);
            end
        end
    endtask

    task automatic test_min_wrap();
        for (int i = 0; i < 5; i++)  press(1, 0, 0);
        for (int i = 0; i < 59; i++) press(0, 1, 0);
        expect_ticks(3, "min_wrap_pre");
        press(0, 1, 0);
        exp_q.push_back(mk_frame());
        sb_pop("min_wrap");
        model_tick();
        exp_q.push_back(mk_frame());
        for (int i = 0; i < 3; i++) begin
            logic want;
            @(negedge clk);
            want = (i == 2);
            n_checks++;
            if (tick_o !== want) begin
                n_fail++;
                $display("FAIL set_restart cycle %0d: tick_o=%b required %b", i + 2, tick_o, want);
            end
        end
        @(negedge clk);
        sb_pop("set_restart");
        press(1, 1, 0);
        exp_q.push_back(mk_frame());
        sb_pop("both_edges");
    endtask

    task automatic test_page();
        press(0, 0, 1);
        exp_q.push_back(mk_frame());
        sb_pop("page_enter");
        expect_ticks(2, "page_hold");
        press(0, 0, 1);
        exp_q.push_back(mk_frame());
        sb_pop("page_reload");
        expect_ticks(1, "page_after_reload");
        press(1, 0, 0);
        exp_q.push_back(mk_frame());
        sb_pop("set_in_secs");
        expect_ticks(2, "page_revert");
    endtask

    task automatic test_12h();
        mode_12h_i = 1'b1;
        for (int i = 0; i < 17; i++) press(1, 0, 0);
        exp_q.push_back(mk_frame());
        sb_pop("h12_midnight");
        for (int i = 0; i < 12; i++) press(1, 0, 0);
        exp_q.push_back(mk_frame());
        sb_pop("h12_noon");
        press(1, 0, 0);
        exp_q.push_back(mk_frame());
        sb_pop("h12_13");
        mode_12h_i = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk_frame());
        sb_pop("h24_13");
    endtask

    task automatic test_reset_mid();
        expect_ticks(1, "mid_align");
        press(0, 0, 1);
        exp_q.push_back(mk_frame());
        sb_pop("mid_secs_page");
        rst_i = 1'b1;
        #1;
        n_checks += 4;
        if (disp_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_disp: got %h required 0000", disp_o); end
        if (blank_o !== 4'b0000) begin n_fail++; $display("FAIL midrst_blank: got %b required 0000", blank_o); end
        if (pm_o !== 1'b0)       begin n_fail++; $display("FAIL midrst_pm: got %b required 0", pm_o); end
        if (colon_o !== 1'b1)    begin n_fail++; $display("FAIL midrst_colon: got %b required 1", colon_o); end
        @(negedge clk);
        rst_i = 1'b0;
        mh = 0; mm = 0; ms = 0; rev = 0; secs_page = 0;
        expect_ticks(1, "after_mid_reset");
    endtask

`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    task automatic test_alarm();
        alarm_hr_i  = 5'd0;
        alarm_min_i = 6'd1;
        alarm_en_i  = 1'b1;
        expect_ticks(58, "alarm_run");
        n_checks++;
        if (alarm_o !== 1'b0) begin n_fail++; $display("FAIL alarm_early: got %b required 0", alarm_o); end
        expect_ticks(1, "alarm_hit");
        n_checks++;
        if (alarm_o !== 1'b1) begin n_fail++; $display("FAIL alarm_set: got %b required 1", alarm_o); end
        alarm_ack_i = 1'b1;
        @(negedge clk);
        alarm_ack_i = 1'b0;
        n_checks++;
        if (alarm_o !== 1'b0) begin n_fail++; $display("FAIL alarm_ack: got %b required 0", alarm_o); end
        alarm_min_i = 6'd3;
        press(0, 1, 0);
        press(0, 1, 0);
        n_checks++;
        if (alarm_o !== 1'b0) begin n_fail++; $display("FAIL alarm_by_button: got %b required 0", alarm_o); end
        alarm_en_i  = 1'b0;
        alarm_min_i = 6'd4;
        expect_ticks(60, "alarm_disabled_run");
        n_checks++;
        if (alarm_o !== 1'b0) begin n_fail++; $display("FAIL alarm_disabled: got %b required 0", alarm_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_rollover();
        test_min_wrap();
        test_page();
        test_12h();
        test_reset_mid();
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
        test_alarm();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d frames left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
